// File: rtl/adi_spi_init_sequencer.sv
// adi_spi_init_sequencer: replays a register init table through an adi_spi_driver_7_8bit
// user port after power-up, then arbitrates single host reads/writes onto the same driver.
module adi_spi_init_sequencer #(
    parameter int                     NUM_REGS     = 8,
    parameter logic [NUM_REGS*16-1:0] INIT_TABLE   = '0,
    parameter int                     POWERUP_WAIT = 1000,
    parameter int                     TIMEOUT_CYC  = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       init_busy,
    output logic       init_done,
    output logic       init_err,
    output logic [7:0] err_index,
    output logic [1:0] err_code,
    input  logic       host_wr_en,
    input  logic [6:0] host_wr_addr,
    input  logic [7:0] host_wr_data,
    input  logic       host_rd_en,
    input  logic [6:0] host_rd_addr,
    output logic [7:0] host_rd_data,
    output logic       host_rd_vld,
    output logic       host_wr_vld,
    output logic       host_busy,
    output logic       drv_wr_en,
    output logic [6:0] drv_wr_addr,
    output logic [7:0] drv_wr_data,
    output logic       drv_rd_en,
    output logic [6:0] drv_rd_addr,
    input  logic [7:0] drv_rd_data,
    input  logic       drv_busy,
    input  logic       drv_wr_vld,
    input  logic       drv_rd_vld
);
    typedef enum logic [3:0] {
        IDLE, PWR_WAIT, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT, CHECK, NEXT,
        H_WR_WAIT, H_RD_WAIT, TIMEOUT
    } state_t;

    // Padding the table to the full 8-bit index range keeps the entry select in range.
    localparam logic [4095:0] TBL = 4096'(INIT_TABLE);

    state_t      state, state_nxt;
    logic [31:0] cnt;
    logic [7:0]  idx, rd_q;
    logic [15:0] entry;
    logic        tmo, last, pwr_done;

    assign entry     = TBL[{idx, 4'h0} +: 16];
    assign tmo       = cnt == 32'(TIMEOUT_CYC - 1);
    assign pwr_done  = cnt + 32'd1 >= 32'(POWERUP_WAIT);
    assign last      = idx == 8'(NUM_REGS - 1);
    assign host_busy = (state != IDLE) | drv_busy;

    always_comb begin
        state_nxt   = state;
        drv_wr_en   = 1'b0;
        drv_rd_en   = 1'b0;
        drv_wr_addr = '0;
        drv_wr_data = '0;
        drv_rd_addr = '0;
        case (state)
            IDLE:
                if (start) state_nxt = PWR_WAIT;
                else if (!drv_busy && host_wr_en) begin
                    drv_wr_en   = 1'b1;
                    drv_wr_addr = host_wr_addr;
                    drv_wr_data = host_wr_data;
                    state_nxt   = H_WR_WAIT;
                end else if (!drv_busy && host_rd_en) begin
                    drv_rd_en   = 1'b1;
                    drv_rd_addr = host_rd_addr;
                    state_nxt   = H_RD_WAIT;
                end
            PWR_WAIT: state_nxt = pwr_done ? WR_ISSUE : PWR_WAIT;
            WR_ISSUE:
                if (!drv_busy) begin
                    drv_wr_en   = 1'b1;
                    drv_wr_addr = entry[14:8];
                    drv_wr_data = entry[7:0];
                    state_nxt   = WR_WAIT;
                end else if (tmo) state_nxt = TIMEOUT;
            WR_WAIT:   state_nxt = drv_wr_vld ? (entry[15] ? RD_ISSUE : NEXT) : tmo ? TIMEOUT : WR_WAIT;
            RD_ISSUE:
                if (!drv_busy) begin
                    drv_rd_en   = 1'b1;
                    drv_rd_addr = entry[14:8];
                    state_nxt   = RD_WAIT;
                end else if (tmo) state_nxt = TIMEOUT;
            RD_WAIT:   state_nxt = drv_rd_vld ? CHECK : tmo ? TIMEOUT : RD_WAIT;
            CHECK:     state_nxt = (rd_q == entry[7:0]) ? NEXT : IDLE;
            NEXT:      state_nxt = last ? IDLE : WR_ISSUE;
            H_WR_WAIT: state_nxt = drv_wr_vld ? IDLE : tmo ? TIMEOUT : H_WR_WAIT;
            H_RD_WAIT: state_nxt = drv_rd_vld ? IDLE : tmo ? TIMEOUT : H_RD_WAIT;
            TIMEOUT:   state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // The operation counter runs across an ISSUE state and its WAIT state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= (state_nxt != state && state_nxt != WR_WAIT && state_nxt != RD_WAIT) ? '0 : cnt + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            init_busy    <= 1'b0;
            init_done    <= 1'b0;
            init_err     <= 1'b0;
            err_index    <= '0;
            err_code     <= '0;
            idx          <= '0;
            rd_q         <= '0;
            host_rd_data <= '0;
            host_rd_vld  <= 1'b0;
            host_wr_vld  <= 1'b0;
        end else begin
            host_wr_vld <= state == H_WR_WAIT && drv_wr_vld;
            host_rd_vld <= state == H_RD_WAIT && drv_rd_vld;
            if (state == H_RD_WAIT && drv_rd_vld) host_rd_data <= drv_rd_data;
            if (state == RD_WAIT && drv_rd_vld) rd_q <= drv_rd_data;
            if (state == IDLE && start) begin
                init_done <= 1'b0;
                init_err  <= 1'b0;
                err_code  <= '0;
                idx       <= '0;
                init_busy <= 1'b1;
            end
            if (state == CHECK && rd_q != entry[7:0]) begin
                init_err  <= 1'b1;
                err_code  <= 2'b01;
                err_index <= idx;
                init_busy <= 1'b0;
            end
            if (state == NEXT) begin
                if (last) begin
                    init_done <= 1'b1;
                    init_busy <= 1'b0;
                end else idx <= idx + 8'd1;
            end
            // Only an init-sequence timeout is reported; host timeouts just free the port.
            if (state == TIMEOUT && init_busy) begin
                init_err  <= 1'b1;
                err_code  <= 2'b10;
                err_index <= idx;
                init_busy <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_adi_spi_init_sequencer.sv
// tb_adi_spi_init_sequencer: randomized scoreboard bench with a behavioural SPI driver/device
// model; expected driver operations and host read data are queued and checked by a monitor.
module tb_adi_spi_init_sequencer;
    localparam int PW = 20;
    localparam int TO = 64;

    logic       clk = 0, rst = 1, start = 0;
    logic       host_wr_en = 0, host_rd_en = 0;
    logic [6:0] host_wr_addr = 0, host_rd_addr = 0;
    logic [7:0] host_wr_data = 0;
    logic       init_busy, init_done, init_err, host_rd_vld, host_wr_vld, host_busy;
    logic [7:0] err_index, host_rd_data;
    logic [1:0] err_code;
    logic       drv_wr_en, drv_rd_en;
    logic [6:0] drv_wr_addr, drv_rd_addr;
    logic [7:0] drv_wr_data;
    logic [7:0] drv_rd_data = 0;
    logic       drv_busy = 0, drv_wr_vld = 0, drv_rd_vld = 0;

    adi_spi_init_sequencer #(
        .NUM_REGS(3), .INIT_TABLE(48'hFFAA_1001_CA55), .POWERUP_WAIT(PW), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .init_busy(init_busy), .init_done(init_done),
        .init_err(init_err), .err_index(err_index), .err_code(err_code),
        .host_wr_en(host_wr_en), .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
        .host_rd_en(host_rd_en), .host_rd_addr(host_rd_addr), .host_rd_data(host_rd_data),
        .host_rd_vld(host_rd_vld), .host_wr_vld(host_wr_vld), .host_busy(host_busy),
        .drv_wr_en(drv_wr_en), .drv_wr_addr(drv_wr_addr), .drv_wr_data(drv_wr_data),
        .drv_rd_en(drv_rd_en), .drv_rd_addr(drv_rd_addr), .drv_rd_data(drv_rd_data),
        .drv_busy(drv_busy), .drv_wr_vld(drv_wr_vld), .drv_rd_vld(drv_rd_vld)
    );

    always #5 clk = ~clk;

    typedef struct { bit rd; logic [6:0] a; logic [7:0] d; } op_t;
    op_t        exp_q[$];
    logic [7:0] exp_rd[$];
    int         tests = 0, fails = 0, cyc = 0;
    logic [6:0] ta[3] = '{7'h4A, 7'h10, 7'h7F};
    logic [7:0] td[3] = '{8'h55, 8'h01, 8'hAA};
    bit         tv[3] = '{1'b1, 1'b0, 1'b1};
    logic [7:0] ref_mem[128] = '{default: 8'h00};

    // Device/driver model: one transfer at a time, random latency, optional faults.
    logic [7:0] dev_mem[128] = '{default: 8'h00};
    logic [7:0] corrupt_addr = 8'hFF;
    bit         hang = 0, m_rd = 0;
    logic [6:0] m_a = 0;
    int         m_lat = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        drv_wr_vld <= 1'b0;
        drv_rd_vld <= 1'b0;
        if (drv_busy) begin
            if (m_lat == 0) begin
                drv_busy <= 1'b0;
                if (m_rd) begin
                    drv_rd_vld  <= 1'b1;
                    drv_rd_data <= ({1'b0, m_a} == corrupt_addr) ? dev_mem[m_a] ^ 8'h01 : dev_mem[m_a];
                end else if (!hang) drv_wr_vld <= 1'b1;
            end else m_lat <= m_lat - 1;
        end else if (drv_wr_en) begin
            dev_mem[drv_wr_addr] <= drv_wr_data;
            drv_busy <= 1'b1;
            m_rd     <= 1'b0;
            m_lat    <= int'($urandom_range(0, 4));
        end else if (drv_rd_en) begin
            drv_busy <= 1'b1;
            m_rd     <= 1'b1;
            m_a      <= drv_rd_addr;
            m_lat    <= int'($urandom_range(0, 4));
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every driver request and host read result is matched against the queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (drv_wr_en || drv_rd_en) begin
                chk("en_exclusive", 32'(drv_wr_en & drv_rd_en), 0);
                chk("en_while_busy", 32'(drv_busy), 0);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_op: got rd=%0b wa=0x%0h wd=0x%0h ra=0x%0h, expected none",
                             drv_rd_en, drv_wr_addr, drv_wr_data, drv_rd_addr);
                end else begin
                    op_t o;
                    o = exp_q.pop_front();
                    chk("op_kind", 32'(drv_rd_en), 32'(o.rd));
                    chk("op_addr", 32'(drv_rd_en ? drv_rd_addr : drv_wr_addr), 32'(o.a));
                    if (!o.rd) chk("op_data", 32'(drv_wr_data), 32'(o.d));
                end
            end
            if (host_rd_vld) begin
                if (exp_rd.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_host_rd: got 0x%0h, expected no read", host_rd_data);
                end else chk("host_rd_data", 32'(host_rd_data), 32'(exp_rd.pop_front()));
            end
        end
    end

    // Reference: walk the table, expecting each write and verify read until the first failure.
    task automatic plan_init(input int bad, input bit hng, output bit e_done, output bit e_err,
                             output logic [1:0] e_code, output logic [7:0] e_idx);
        e_done = 1; e_err = 0; e_code = 0; e_idx = 0;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back('{rd: 1'b0, a: ta[i], d: td[i]});
            ref_mem[ta[i]] = td[i];
            if (hng) begin e_done = 0; e_err = 1; e_code = 2'b10; e_idx = 8'(i); return; end
            if (tv[i]) begin
                exp_q.push_back('{rd: 1'b1, a: ta[i], d: 8'h00});
                if (i == bad) begin e_done = 0; e_err = 1; e_code = 2'b01; e_idx = 8'(i); return; end
            end
        end
    endtask

    task automatic run_init(input int bad, input bit hng, input bit with_host);
        bit e_done, e_err;
        logic [1:0] e_code;
        logic [7:0] e_idx;
        int n, t0;
        plan_init(bad, hng, e_done, e_err, e_code, e_idx);
        corrupt_addr = bad >= 0 ? {1'b0, ta[bad]} : 8'hFF;
        hang = hng;
        @(posedge clk); #1;
        start = 1;
        if (with_host) begin host_wr_en = 1; host_wr_addr = 7'h33; host_wr_data = 8'hC3; end
        @(posedge clk); #1;
        start = 0; host_wr_en = 0; t0 = cyc;
        chk("init_busy_set", 32'(init_busy), 1);
        chk("flags_cleared", 32'({init_done, init_err, err_code}), 0);
        if (with_host) begin
            host_wr_en = 1; host_wr_addr = 7'h11;
            @(posedge clk); #1;
            host_wr_en = 0;
            chk("host_busy_pwr_wait", 32'(host_busy), 1);
        end
        n = 0;
        while (!(init_done || init_err) && n < 3000) begin @(posedge clk); #1; n++; end
        chk("init_finished", 32'(n < 3000), 1);
        chk("init_done", 32'(init_done), 32'(e_done));
        chk("init_err", 32'(init_err), 32'(e_err));
        chk("err_code", 32'(err_code), 32'(e_code));
        if (e_err) chk("err_index", 32'(err_index), 32'(e_idx));
        if (hng) chk("timeout_latency_ok", 32'(cyc - t0 >= PW + TO && cyc - t0 <= PW + TO + 4), 1);
        chk("init_busy_clear", 32'(init_busy), 0);
        chk("ops_outstanding", 32'(exp_q.size()), 0);
        hang = 0;
        corrupt_addr = 8'hFF;
        exp_q.delete();
    endtask

    task automatic host_op(input bit wr, input logic [6:0] a, input logic [7:0] d, input bit both);
        int n;
        bit busy_ok;
        n = 0;
        while (host_busy && n < 200) begin @(posedge clk); #1; n++; end
        if (wr) begin
            exp_q.push_back('{rd: 1'b0, a: a, d: d});
            ref_mem[a] = d;
        end else begin
            exp_q.push_back('{rd: 1'b1, a: a, d: 8'h00});
            exp_rd.push_back(ref_mem[a]);
        end
        host_wr_en = wr; host_wr_addr = a; host_wr_data = d;
        host_rd_en = !wr || both; host_rd_addr = a ^ 7'h01;
        if (!wr) host_rd_addr = a;
        @(posedge clk); #1;
        host_wr_en = 0; host_rd_en = 0;
        busy_ok = 1; n = 0;
        while (!(wr ? host_wr_vld : host_rd_vld) && n < 200) begin
            busy_ok &= host_busy;
            @(posedge clk); #1; n++;
        end
        chk(wr ? "host_wr_vld_seen" : "host_rd_vld_seen", 32'(n < 200), 1);
        chk("host_busy_held", 32'(busy_ok), 1);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_flags"}, 32'({init_busy, init_done, init_err, host_rd_vld, host_wr_vld, drv_wr_en, drv_rd_en}), 0);
        chk({tag, "_err"}, 32'({err_index, err_code}), 0);
        chk({tag, "_rd_data"}, 32'(host_rd_data), 0);
        chk({tag, "_drv_bus"}, 32'({drv_wr_addr, drv_wr_data, drv_rd_addr}), 0);
        chk({tag, "_host_busy"}, 32'(host_busy), 32'(drv_busy));
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 0;
        run_init(-1, 0, 1);
        run_init(0, 0, 0);
        for (int r = 0; r < 3; r++) run_init(int'($urandom_range(0, 3)) - 1, 0, 0);
        run_init(-1, 1, 0);
        begin
            bit e_done, e_err;
            logic [1:0] e_code;
            logic [7:0] e_idx;
            plan_init(-1, 0, e_done, e_err, e_code, e_idx);
            @(posedge clk); #1 start = 1;
            @(posedge clk); #1 start = 0;
            n = 0;
            do begin @(negedge clk); n++; end while (!(drv_wr_en && drv_wr_addr == 7'h10) && n < 3000);
            chk("reached_entry1_write", 32'(n < 3000), 1);
            @(posedge clk); #1 rst = 1;
            exp_q.delete();
            @(posedge clk); #1;
            check_zero("midop_reset");
            rst = 0;
        end
        run_init(-1, 0, 0);
        host_op(1, 7'h5A, 8'hAA, 0);
        host_op(0, 7'h5A, 8'h00, 0);
        host_op(0, 7'h4A, 8'h00, 0);
        for (int k = 0; k < 12; k++) begin
            bit wr;
            wr = 1'($urandom_range(0, 1));
            host_op(wr, 7'($urandom_range(0, 127)), 8'($urandom), wr && $urandom_range(0, 2) == 0);
        end
        repeat (10) @(posedge clk);
        #1;
        chk("host_rd_pending", 32'(exp_rd.size()), 0);
        chk("ops_pending", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected finish within 50000 cycles");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/adi_spi_init_sequencer.md
Name: adi_spi_init_sequencer

Overview:
- Controller in front of adi_spi_driver_7_8bit: owns the driver's user request port.
- On start, waits a power-up delay, then replays a parameterised table of 7-bit-address/8-bit-data register writes, with optional read-back verify per entry.
- After init, or when idle, arbitrates single host write/read requests onto the same driver.

Parameters:
- NUM_REGS, 8, number of init table entries (1..255).
- INIT_TABLE, all zeros (NUM_REGS*16 bits), entry i at [16i+15:16i].
  - bit15: verify flag.
  - [14:8]: address.
  - [7:0]: data.
- POWERUP_WAIT, 1000, clk cycles between start and the first write.
- TIMEOUT_CYC, 4096, max cycles spent waiting on any single driver operation.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- start  in  1  one-cycle pulse: begin init sequence
- init_busy  out  1  sequence in progress
- init_done  out  1  sticky: all entries written/verified
- init_err  out  1  sticky: verify mismatch or timeout
- err_index  out  8  table index of failing entry
- err_code  out  2  01 = mismatch, 10 = timeout
- host_wr_en  in  1  host write request pulse
- host_wr_addr  in  7  host write address
- host_wr_data  in  8  host write data
- host_rd_en  in  1  host read request pulse
- host_rd_addr  in  7  host read address
- host_rd_data  out  8  host read result
- host_rd_vld  out  1  one-cycle pulse: host_rd_data valid
- host_wr_vld  out  1  one-cycle pulse: host write complete
- host_busy  out  1  host request cannot be accepted
- drv_wr_en  out  1  to driver user_wr_en
- drv_wr_addr  out  7  to driver user_wr_addr
- drv_wr_data  out  8  to driver user_wr_data
- drv_rd_en  out  1  to driver user_rd_en
- drv_rd_addr  out  7  to driver user_rd_addr
- drv_rd_data  in  8  from driver user_rd_data
- drv_busy  in  1  from driver user_op_busy
- drv_wr_vld  in  1  from driver user_wr_vild
- drv_rd_vld  in  1  from driver user_rd_vild

Behaviour:
- Reset: all outputs 0, err_index 0, counters 0, state IDLE. rst mid-operation aborts immediately; any driver transfer already issued completes unobserved.
- States: IDLE, PWR_WAIT, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT, CHECK, NEXT, H_WR_WAIT, H_RD_WAIT, TIMEOUT.
- IDLE + start:
  - Clear init_done, init_err, err_code; index := 0; init_busy := 1; go to PWR_WAIT.
  - start has priority over a same-cycle host request; that request is dropped.
- PWR_WAIT: counts POWERUP_WAIT cycles, then WR_ISSUE.
- WR_ISSUE:
  - Waits for drv_busy == 0.
  - Drives drv_wr_en for exactly 1 cycle, with addr/data of entry[index]; go to WR_WAIT.
- WR_WAIT on drv_wr_vld:
  - verify flag set: go to RD_ISSUE.
  - verify flag clear: go to NEXT.
- RD_ISSUE: one-cycle drv_rd_en at the same address, after drv_busy == 0. RD_WAIT on drv_rd_vld captures drv_rd_data and goes to CHECK.
- CHECK:
  - Mismatch: init_err := 1, err_code := 01, err_index := index, init_busy := 0, go to IDLE. Remaining entries are skipped.
  - Match: go to NEXT.
- NEXT:
  - index == NUM_REGS-1: init_done := 1, init_busy := 0, go to IDLE.
  - Otherwise index += 1, go to WR_ISSUE.
- Timeout:
  - Per-operation counter reset on each entry into any *_ISSUE state.
  - Reaching TIMEOUT_CYC in any ISSUE/WAIT state: init_err := 1, err_code := 10, err_index := index, go to IDLE.
  - Host operation timeout returns to IDLE without setting init_err.
- Host arbitration:
  - host_busy = (state != IDLE) | drv_busy.
  - In IDLE with host_busy low, host_wr_en is accepted: one-cycle drv_wr_en, go to H_WR_WAIT. drv_wr_vld produces a host_wr_vld pulse, then IDLE.
  - host_rd_en follows the same path via H_RD_WAIT. drv_rd_vld latches host_rd_data, produces a host_rd_vld pulse, then IDLE.
  - Simultaneous host_wr_en and host_rd_en: write wins, read dropped.
  - Requests while host_busy is high are ignored, not queued.
- start while not IDLE: ignored.
- init_done and init_err are never both 1.
- drv_wr_en and drv_rd_en are never both 1, and never asserted while drv_busy == 1.
- host_rd_data holds its value until the next host read.

Test Plan:
- NUM_REGS=3, table {8000_4A55, 0000_1001, 8000_7FAA}, model echoes writes → exactly 3 drv_wr_en pulses in order 4A/55, 10/01, 7F/AA; 2 reads (4A, 7F); init_done=1, init_err=0.
- Same table, model returns 0x54 for 4A → init_err=1, err_code=01, err_index=0; no write to 0x10 issued.
- Model never asserts drv_wr_vld, TIMEOUT_CYC=64 → init_err=1, err_code=10, err_index=0 after 64 cycles; returns to IDLE.
- After init_done, host_rd_en at 0x5A, model returns 0xAA → single drv_rd_en at addr 0x5A; host_rd_vld pulse with host_rd_data=0xAA; host_busy high throughout.
- start and host_wr_en on the same cycle → sequence starts, host write never issued; host_wr_en during PWR_WAIT ignored.
- rst asserted in WR_WAIT of entry 1 → all outputs 0 next cycle; a fresh start replays from entry 0.
